if_stage_q: RTL and testbench

- Fetch stage for the 5-stage LoongArch core, replacing the fixed 1-cycle SRAM fetch with a decoupled front end.
- Issues in-order instruction requests on an SRAM-like bus (req/addr_ok/data_ok) with variable latency.
- Holds up to MAX_OUTSTANDING requests in flight and buffers fetched instructions in an IBUF_DEPTH queue feeding ID.
- Handles exception/branch redirects, cancelling in-flight responses, and raises ADEF for misaligned PCs.

---
 rtl/if_stage_q_pkg.sv | 19 +
 rtl/if_stage_q_ibuf.sv | 86 ++++++++
 rtl/if_stage_q.sv | 149 ++++++++++++++
 tb/tb_if_stage_q.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_q_pkg.sv
`default_nettype none
// if_stage_q_pkg: shared constants and the instruction-queue entry layout for the fetch stage.
// Revision 1.0
package if_stage_q_pkg;

  localparam logic [31:0] C_RESET_PC  = 32'h1c00_0000;
  localparam logic [1:0]  C_SIZE_WORD = 2'd2;
  localparam int          C_IBUF_W    = 32 + 32 + 1;
  localparam int          C_CANCEL_W  = 8;

  // Field order matches the to_ID bundle: {pc, inst, adef}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } ibuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_q_ibuf.sv
`default_nettype none
// if_ibuf: in-order instruction queue; slots are reserved at issue, filled on response, popped by ID.
// Revision 1.0
module if_ibuf
  import if_stage_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_reserve,
  input  logic        i_push_adef,
  input  logic [31:0] i_pc,
  input  logic        i_fill,
  input  logic [31:0] i_fill_inst,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_head_valid,
  output logic [31:0] o_head_pc,
  output logic [31:0] o_head_inst,
  output logic        o_head_adef
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

  logic [AW:0]         r_head;
  logic [AW:0]         r_fill;
  logic [AW:0]         r_tail;
  logic [DEPTH-1:0]    r_filled;
  ibuf_entry_t         r_mem [DEPTH];

  logic [AW:0]         w_count;
  logic [AW-1:0]       w_head_idx;
  logic [AW-1:0]       w_fill_idx;
  logic [AW-1:0]       w_tail_idx;
  logic [C_IBUF_W-1:0] w_head_raw;

  // The extra pointer bit separates a full queue from an empty one.
  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[AW-1:0];
  assign w_fill_idx = r_fill[AW-1:0];
  assign w_tail_idx = r_tail[AW-1:0];

  assign o_full       = (w_count == C_DEPTH);
  assign o_head_valid = (w_count != '0) & r_filled[w_head_idx];
  assign w_head_raw   = r_mem[w_head_idx];
  assign {o_head_pc, o_head_inst, o_head_adef} = w_head_raw;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
    end else begin
      if (i_reserve || i_push_adef) r_tail <= r_tail + 1'b1;
      if (i_fill || i_push_adef)    r_fill <= r_fill + 1'b1;
      if (i_pop)                    r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_filled <= '0;
    end else if (!i_clear) begin
      if (i_reserve)        r_filled[w_tail_idx] <= 1'b0;
      else if (i_push_adef) r_filled[w_tail_idx] <= 1'b1;
      if (i_fill)           r_filled[w_fill_idx] <= 1'b1;
    end
  end

  // An ADEF entry is born filled with a zero instruction.
  always_ff @(posedge clk) begin
    if (!reset && !i_clear) begin
      if (i_reserve || i_push_adef) begin
        r_mem[w_tail_idx].pc   <= i_pc;
        r_mem[w_tail_idx].inst <= 32'd0;
        r_mem[w_tail_idx].adef <= i_push_adef;
      end
      if (i_fill) r_mem[w_fill_idx].inst <= i_fill_inst;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage_q.sv
`default_nettype none
// if_stage_q: decoupled fetch stage -- PC, bus issue, redirect cancellation and ADEF halt.
// Revision 1.0
module if_stage_q
  import if_stage_q_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = C_RESET_PC,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_flush,
  input  logic [31:0] ex_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        ID_allow_in,
  output logic        IF_to_ID_valid,
  output logic [31:0] to_ID_pc,
  output logic [31:0] to_ID_inst,
  output logic        to_ID_adef
);

  localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] C_MAX_OUT = MAX_OUTSTANDING[OW-1:0];

  logic [31:0]           r_fetch_pc;
  logic [31:0]           r_hold_addr;
  logic                  r_req_hold;
  logic                  r_stale;
  logic                  r_halt;
  logic [OW-1:0]         r_outstanding;
  logic [C_CANCEL_W-1:0] r_cancel_cnt;

  logic                  w_redirect;
  logic [31:0]           w_redirect_pc;
  logic                  w_full;
  logic                  w_head_valid;
  logic                  w_can_issue;
  logic                  w_accept;
  logic                  w_accept_stale;
  logic                  w_accept_live;
  logic                  w_resp_drop;
  logic                  w_resp_live;
  logic                  w_adef_push;
  logic                  w_pop;
  logic [OW-1:0]         w_out_next;
  logic [C_CANCEL_W-1:0] w_cancel_next;

  assign w_redirect    = ex_flush | br_taken;
  assign w_redirect_pc = ex_flush ? ex_entry : br_target;

  assign w_can_issue = !w_redirect && !r_halt && (r_fetch_pc[1:0] == 2'b00) &&
                       !w_full && (r_outstanding < C_MAX_OUT);

  // A held request is never withdrawn, even across a redirect.
  assign inst_req   = !reset && (r_req_hold || w_can_issue);
  assign inst_addr  = r_req_hold ? r_hold_addr : r_fetch_pc;
  assign inst_wr    = 1'b0;
  assign inst_size  = C_SIZE_WORD;
  assign inst_wdata = 32'd0;

  // Anything accepted during or after a redirect belongs to the abandoned stream.
  assign w_accept       = inst_req && inst_addr_ok;
  assign w_accept_stale = w_accept && (r_stale || w_redirect);
  assign w_accept_live  = w_accept && !w_accept_stale;

  assign w_resp_drop = inst_data_ok && ((r_cancel_cnt != '0) || w_redirect);
  assign w_resp_live = inst_data_ok && !w_resp_drop;

  assign w_adef_push = !reset && !w_redirect && !r_halt && (r_fetch_pc[1:0] != 2'b00) &&
                       (r_outstanding == '0) && (r_cancel_cnt == '0) && !w_full;

  assign IF_to_ID_valid = !reset && w_head_valid && !w_redirect;
  assign w_pop          = IF_to_ID_valid && ID_allow_in;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept_live) w_out_next = w_out_next + 1'b1;
    if (w_resp_live)   w_out_next = w_out_next - 1'b1;
  end

  // On redirect every live in-flight request turns into one to be discarded.
  always_comb begin
    w_cancel_next = r_cancel_cnt;
    if (w_redirect)     w_cancel_next = w_cancel_next + C_CANCEL_W'(r_outstanding);
    if (w_accept_stale) w_cancel_next = w_cancel_next + 1'b1;
    if (w_resp_drop)    w_cancel_next = w_cancel_next - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_hold_addr   <= 32'd0;
      r_req_hold    <= 1'b0;
      r_stale       <= 1'b0;
      r_halt        <= 1'b0;
      r_outstanding <= '0;
      r_cancel_cnt  <= '0;
    end else begin
      r_outstanding <= w_redirect ? '0 : w_out_next;
      r_cancel_cnt  <= w_cancel_next;

      if (w_redirect)         r_fetch_pc <= w_redirect_pc;
      else if (w_accept_live) r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_redirect)       r_halt <= 1'b0;
      else if (w_adef_push) r_halt <= 1'b1;

      if (w_accept) begin
        r_req_hold <= 1'b0;
        r_stale    <= 1'b0;
      end else if (inst_req) begin
        r_req_hold  <= 1'b1;
        r_hold_addr <= inst_addr;
        r_stale     <= r_stale || w_redirect;
      end
    end
  end

  if_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_redirect),
    .i_reserve    (w_accept_live),
    .i_push_adef  (w_adef_push),
    .i_pc         (r_fetch_pc),
    .i_fill       (w_resp_live),
    .i_fill_inst  (inst_rdata),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_head_valid (w_head_valid),
    .o_head_pc    (to_ID_pc),
    .o_head_inst  (to_ID_inst),
    .o_head_adef  (to_ID_adef)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_stage_q.sv
`default_nettype none
// tb_if_stage_q: directed and randomized checks of if_stage_q against a program-order stream model.
// Revision 1.0
module tb_if_stage_q;

  logic        clk;
  logic        reset;
  logic        ex_flush;
  logic [31:0] ex_entry;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ID_allow_in;
  logic        IF_to_ID_valid;
  logic [31:0] to_ID_pc;
  logic [31:0] to_ID_inst;
  logic        to_ID_adef;

  if_stage_q dut (
    .clk            (clk),
    .reset          (reset),
    .ex_flush       (ex_flush),
    .ex_entry       (ex_entry),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .ID_allow_in    (ID_allow_in),
    .IF_to_ID_valid (IF_to_ID_valid),
    .to_ID_pc       (to_ID_pc),
    .to_ID_inst     (to_ID_inst),
    .to_ID_adef     (to_ID_adef)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } bus_t;

  bus_t        bq[$];
  logic [31:0] acc_q[$];
  int          checks, errors, cyc;
  int          ok_mode, ok_pct, allow_mode, allow_pct, lat_min, lat_max;
  int          pops, req_cnt;
  logic [31:0] exp_pc;
  bit          exp_done;
  logic        prev_req, prev_ok;
  logic [31:0] prev_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 99) < 15) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: drive bus/ID, check outputs against the stream model, advance.
  task automatic cycle();
    int lat;
    inst_addr_ok = (ok_mode < 0) ? (int'($urandom_range(0, 99)) < ok_pct) : ok_mode[0];
    ID_allow_in  = (allow_mode < 0) ? (int'($urandom_range(0, 99)) < allow_pct) : allow_mode[0];
    if (!reset && bq.size() > 0 && bq[0].ready <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = inst_of(bq[0].addr);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    #1;
    if (reset) begin
      chk1("reset_req", inst_req, 1'b0);
      chk1("reset_valid", IF_to_ID_valid, 1'b0);
    end else begin
      chk1("wr_const", inst_wr, 1'b0);
      chk32("size_const", 32'(inst_size), 32'd2);
      chk32("wdata_const", inst_wdata, 32'd0);
      if (prev_req && !prev_ok) begin
        chk1("hold_req", inst_req, 1'b1);
        chk32("hold_addr", inst_addr, prev_addr);
      end
      if (ex_flush || br_taken) chk1("redirect_valid", IF_to_ID_valid, 1'b0);
      if (IF_to_ID_valid && ID_allow_in) begin
        pops++;
        if (exp_done) begin
          chk1("valid_after_adef", IF_to_ID_valid, 1'b0);
        end else begin
          chk32("pop_pc", to_ID_pc, exp_pc);
          if (exp_pc[1:0] != 2'b00) begin
            chk1("pop_adef", to_ID_adef, 1'b1);
            chk32("pop_adef_inst", to_ID_inst, 32'd0);
            exp_done = 1'b1;
          end else begin
            chk1("pop_noadef", to_ID_adef, 1'b0);
            chk32("pop_inst", to_ID_inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      if (inst_req) req_cnt++;
      if (inst_req && inst_addr_ok) begin
        lat = int'($urandom_range(lat_min, lat_max));
        acc_q.push_back(inst_addr);
        bq.push_back('{inst_addr, cyc + lat});
      end
      if (inst_data_ok) void'(bq.pop_front());
      if (ex_flush || br_taken) begin
        exp_pc   = ex_flush ? ex_entry : br_target;
        exp_done = 1'b0;
      end
    end
    prev_req  = inst_req && !reset;
    prev_ok   = inst_addr_ok;
    prev_addr = inst_addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Responses still owed at reset are simply forgotten by the bus model.
  task automatic do_reset();
    reset    = 1'b1;
    ex_flush = 1'b0;
    br_taken = 1'b0;
    bq.delete();
    run(2);
    reset    = 1'b0;
    exp_pc   = 32'h1c00_0000;
    exp_done = 1'b0;
    prev_req = 1'b0;
    acc_q.delete();
  endtask

  task automatic redirect(input logic ex, input logic [31:0] ex_pc, input logic br,
                          input logic [31:0] br_pc);
    ex_flush  = ex;
    ex_entry  = ex_pc;
    br_taken  = br;
    br_target = br_pc;
    cycle();
    ex_flush  = 1'b0;
    br_taken  = 1'b0;
  endtask

  initial begin
    int n, p0, r0, stall, last_pops, rr;
    clk = 1'b0; reset = 1'b1; ex_flush = 1'b0; br_taken = 1'b0;
    ex_entry = 32'd0; br_target = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = 32'd0; ID_allow_in = 1'b0;
    checks = 0; errors = 0; cyc = 0; pops = 0; req_cnt = 0;
    prev_req = 1'b0; prev_ok = 1'b0; prev_addr = 32'd0;
    ok_pct = 100; allow_pct = 100;

    // Streaming fetch with 1-cycle response latency.
    ok_mode = 1; allow_mode = 1; lat_min = 1; lat_max = 1;
    do_reset();
    run(6);
    chk32("t1_addr0", acc_at(0), 32'h1c00_0000);
    chk32("t1_addr1", acc_at(1), 32'h1c00_0004);
    chk32("t1_addr2", acc_at(2), 32'h1c00_0008);
    p0 = pops;
    run(6);
    chk32("t1_steady_pops", pops - p0, 32'd6);

    // ID stalled: only IBUF_DEPTH requests may be accepted.
    allow_mode = 0;
    do_reset();
    run(10);
    chk32("t2_accepts", acc_q.size(), 32'd4);
    chk1("t2_req_stopped", inst_req, 1'b0);
    allow_mode = 1;
    p0 = pops;
    run(10);
    chk1("t2_resume", acc_q.size() > 4, 1'b1);
    chk1("t2_drained", (pops - p0) >= 4, 1'b1);

    // Branch with two requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    do_reset();
    run(2);
    chk32("t3_inflight", acc_q.size(), 32'd2);
    redirect(1'b0, 32'd0, 1'b1, 32'h1c00_0100);
    run(15);
    chk32("t3_next_addr", acc_at(2), 32'h1c00_0100);

    // Held request across an exception redirect.
    lat_min = 1; lat_max = 1;
    do_reset();
    run(2);
    ok_mode = 0;
    run(3);
    chk1("t4_held_req", inst_req, 1'b1);
    chk32("t4_held_addr", inst_addr, 32'h1c00_0008);
    redirect(1'b1, 32'h1c00_0800, 1'b0, 32'd0);
    run(1);
    chk32("t4_still_held", inst_addr, 32'h1c00_0008);
    ok_mode = 1;
    run(12);
    chk32("t4_stale_accept", acc_at(2), 32'h1c00_0008);
    chk32("t4_next_addr", acc_at(3), 32'h1c00_0800);

    // Misaligned branch target raises ADEF and halts fetch.
    lat_min = 1; lat_max = 2;
    do_reset();
    run(5);
    redirect(1'b0, 32'd0, 1'b1, 32'h1c00_0102);
    r0 = req_cnt; p0 = pops;
    run(20);
    chk32("t5_no_req", req_cnt - r0, 32'd0);
    chk32("t5_one_entry", pops - p0, 32'd1);
    n = acc_q.size();
    redirect(1'b1, 32'h1c00_8000, 1'b0, 32'd0);
    p0 = pops;
    run(10);
    chk32("t5_resume_addr", acc_at(n), 32'h1c00_8000);
    chk1("t5_resume_pops", (pops - p0) > 0, 1'b1);

    // Simultaneous exception and branch: exception wins.
    do_reset();
    run(3);
    n = acc_q.size();
    redirect(1'b1, 32'h1c00_1000, 1'b1, 32'h1c00_2000);
    run(10);
    chk32("t6_priority", acc_at(n), 32'h1c00_1000);

    // Randomized traffic against the stream model.
    ok_mode = -1; allow_mode = -1; allow_pct = 70; lat_min = 1; lat_max = 4;
    do_reset();
    stall = 0; last_pops = pops;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) ok_pct = int'($urandom_range(30, 100));
      ex_entry  = rand_target();
      br_target = rand_target();
      rr        = int'($urandom_range(0, 99));
      ex_flush  = (rr < 2);
      br_taken  = (rr >= 1 && rr < 5);
      if (ex_flush || br_taken) stall = 0;
      cycle();
      ex_flush = 1'b0;
      br_taken = 1'b0;
      if (pops != last_pops || exp_done) stall = 0;
      else stall++;
      last_pops = pops;
      if (stall > 300) begin
        chk32("liveness_stall", stall, 32'd0);
        stall = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
